// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter for the RV32 core: sequences fetch and load/store
// onto one external bus, with alternating priority under contention and a hang timeout.
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [3:0]        dm_sel,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_sel,
   output logic              bus_read,
   output logic              bus_write,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_err,
   output logic              stall
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_grant_q;   // 1 = last completed grant was DATA
   logic [ADDR_W-1:0] bus_addr_q;
   logic [DATA_W-1:0] bus_wdata_q, if_rdata_q, dm_rdata_q;
   logic [3:0]        bus_sel_q;
   logic              bus_read_q, bus_write_q, if_ack_q, dm_ack_q, bus_err_q;
   logic              data_req, timeout_hit;

   always_comb begin
      data_req    = dm_read | dm_write;
      cnt_d       = cnt_q + 1'b1;
      // Strobes are visible for exactly TIMEOUT_CYCLES cycles before a forced completion.
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == CNT_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_sel_q    <= '0;
         bus_read_q   <= 1'b0;
         bus_write_q  <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         if_ack_q     <= 1'b0;
         dm_ack_q     <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         if_ack_q  <= 1'b0;
         dm_ack_q  <= 1'b0;
         bus_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Data normally wins; fetch wins only if data had the previous grant.
               if (data_req && !(if_req && last_grant_q)) begin
                  state_q     <= DATA;
                  cnt_q       <= '0;
                  bus_addr_q  <= dm_addr;
                  bus_wdata_q <= dm_wdata;
                  bus_sel_q   <= dm_sel;
                  bus_write_q <= dm_write;
                  bus_read_q  <= dm_read & ~dm_write;
               end else if (if_req) begin
                  state_q     <= FETCH;
                  cnt_q       <= '0;
                  bus_addr_q  <= if_addr;
                  bus_wdata_q <= '0;
                  bus_sel_q   <= 4'hF;
                  bus_write_q <= 1'b0;
                  bus_read_q  <= 1'b1;
               end
            end
            FETCH, DATA: begin
               if (bus_ack || timeout_hit) begin
                  state_q      <= IDLE;
                  bus_read_q   <= 1'b0;
                  bus_write_q  <= 1'b0;
                  last_grant_q <= (state_q == DATA);
                  bus_err_q    <= ~bus_ack;
                  if (state_q == FETCH) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= bus_ack ? bus_rdata : '0;
                  end else begin
                     dm_ack_q   <= 1'b1;
                     dm_rdata_q <= (bus_ack && !bus_write_q) ? bus_rdata : '0;
                  end
               end else if (TIMEOUT_CYCLES != 0) begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_ack    = dm_ack_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_sel   = bus_sel_q;
   assign bus_read  = bus_read_q;
   assign bus_write = bus_write_q;
   assign bus_err   = bus_err_q;
   assign stall     = (if_req & ~if_ack_q) | (data_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT_CYCLES=4): arbitration order,
// bus holding, ack/rdata timing, timeout, mid-transaction reset, back-to-back fetch.
module tb_mem_bus_arbiter;
   logic        clk, rst;
   logic        if_req, if_ack, dm_read, dm_write, dm_ack;
   logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_sel, bus_sel;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_read, bus_write, bus_ack, bus_err, stall;
   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_sel(dm_sel), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
      .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .bus_err(bus_err), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
      dm_addr = 0; dm_wdata = 0; dm_sel = 0; bus_rdata = 0; bus_ack = 0;
      step();
      chk("rst_bus_read", {31'd0, bus_read}, 0);
      chk("rst_bus_write", {31'd0, bus_write}, 0);
      chk("rst_acks", {30'd0, if_ack, dm_ack}, 0);
      chk("rst_err_stall", {30'd0, bus_err, stall}, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_bus_addr", bus_addr, 0);
      rst = 1'b0;
      step();

      // Single fetch, ack in third strobe cycle
      if_req = 1; if_addr = 32'h10;
      #1 chk("f1_stall_pre", {31'd0, stall}, 1);
      step();
      chk("f1_read", {31'd0, bus_read}, 1);
      chk("f1_addr", bus_addr, 32'h10);
      chk("f1_sel", {28'd0, bus_sel}, 32'hF);
      chk("f1_wdata", bus_wdata, 0);
      step();
      chk("f1_hold_read", {31'd0, bus_read}, 1);
      chk("f1_hold_addr", bus_addr, 32'h10);
      chk("f1_no_ack", {31'd0, if_ack}, 0);
      step();
      chk("f1_stall_wait", {31'd0, stall}, 1);
      bus_ack = 1; bus_rdata = 32'h0051_0093;
      step();
      chk("f1_ack", {31'd0, if_ack}, 1);
      chk("f1_rdata", if_rdata, 32'h0051_0093);
      chk("f1_strobe_drop", {31'd0, bus_read}, 0);
      chk("f1_stall_ack", {31'd0, stall}, 0);
      if_req = 0; bus_ack = 0; bus_rdata = 32'h1111_1111;
      step();
      chk("f1_ack_pulse", {31'd0, if_ack}, 0);
      chk("f1_rdata_hold", if_rdata, 32'h0051_0093);

      // Contention: data first, then fetch
      dm_write = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_sel = 4'b0011;
      if_req = 1; if_addr = 32'h20;
      step();
      chk("c1_write", {31'd0, bus_write}, 1);
      chk("c1_read", {31'd0, bus_read}, 0);
      chk("c1_sel", {28'd0, bus_sel}, 32'h3);
      chk("c1_addr", bus_addr, 32'h100);
      chk("c1_wdata", bus_wdata, 32'hDEAD_BEEF);
      bus_ack = 1; bus_rdata = 32'h2222_2222;
      step();
      chk("c1_dm_ack", {31'd0, dm_ack}, 1);
      chk("c1_dm_rdata", dm_rdata, 0);
      chk("c1_if_ack", {31'd0, if_ack}, 0);
      chk("c1_stall", {31'd0, stall}, 1);
      dm_write = 0; bus_ack = 0;
      step();
      chk("c2_read", {31'd0, bus_read}, 1);
      chk("c2_addr", bus_addr, 32'h20);
      chk("c2_sel", {28'd0, bus_sel}, 32'hF);
      chk("c2_wdata", bus_wdata, 0);
      bus_ack = 1; bus_rdata = 32'h0000_1234;
      step();
      chk("c2_if_ack", {31'd0, if_ack}, 1);
      chk("c2_if_rdata", if_rdata, 32'h0000_1234);
      if_addr = 32'h24; dm_read = 1; dm_addr = 32'h200; bus_ack = 0;
      step();
      chk("c3_data_again", bus_addr, 32'h200);
      chk("c3_read", {31'd0, bus_read}, 1);
      chk("c3_write", {31'd0, bus_write}, 0);
      bus_ack = 1; bus_rdata = 32'h0000_CAFE;
      step();
      chk("c3_dm_ack", {31'd0, dm_ack}, 1);
      chk("c3_dm_rdata", dm_rdata, 32'h0000_CAFE);
      dm_read = 0; bus_ack = 0;
      step();
      chk("c4_fetch_addr", bus_addr, 32'h24);
      chk("c4_read", {31'd0, bus_read}, 1);
      bus_ack = 1; bus_rdata = 32'h0000_0024;
      step();
      chk("c4_if_ack", {31'd0, if_ack}, 1);
      if_req = 0; bus_ack = 0;
      step();

      // Read+write together: write wins, no read data
      dm_read = 1; dm_write = 1; dm_addr = 32'h300; dm_wdata = 32'h55; dm_sel = 4'hF;
      step();
      chk("rw_write", {31'd0, bus_write}, 1);
      chk("rw_read", {31'd0, bus_read}, 0);
      bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
      step();
      chk("rw_ack", {31'd0, dm_ack}, 1);
      chk("rw_rdata", dm_rdata, 0);
      dm_read = 0; dm_write = 0; bus_ack = 0;
      step();

      // Timeout: strobe visible 4 cycles, then forced completion
      dm_read = 1; dm_addr = 32'h400; bus_rdata = 32'hBAD0_BAD0;
      step();
      chk("to_read", {31'd0, bus_read}, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("to_wait_ack", {30'd0, dm_ack, bus_err}, 0);
         chk("to_wait_read", {31'd0, bus_read}, 1);
      end
      step();
      chk("to_ack_err", {30'd0, dm_ack, bus_err}, 32'h3);
      chk("to_rdata", dm_rdata, 0);
      chk("to_strobe", {31'd0, bus_read}, 0);
      dm_read = 0; if_req = 1; if_addr = 32'h40;
      step();
      chk("to_err_pulse", {31'd0, bus_err}, 0);
      chk("to_next_fetch", {31'd0, bus_read}, 1);
      chk("to_next_addr", bus_addr, 32'h40);
      bus_ack = 1; bus_rdata = 32'h0000_0040;
      step();
      chk("to_next_ack", {31'd0, if_ack}, 1);
      chk("to_next_rdata", if_rdata, 32'h0000_0040);
      if_req = 0; bus_ack = 0;
      step();

      // bus_ack on the timeout cycle wins
      dm_read = 1; dm_addr = 32'h500;
      step();
      step();
      step();
      step();
      bus_ack = 1; bus_rdata = 32'h0000_7777;
      step();
      chk("tb_ack", {31'd0, dm_ack}, 1);
      chk("tb_no_err", {31'd0, bus_err}, 0);
      chk("tb_rdata", dm_rdata, 32'h0000_7777);
      dm_read = 0; bus_ack = 0;
      step();

      // Reset two cycles into a fetch
      if_req = 1; if_addr = 32'h80;
      step();
      chk("rf_read", {31'd0, bus_read}, 1);
      step();
      step();
      rst = 1;
      #1 chk("rf_strobe_drop", {31'd0, bus_read}, 0);
      #2 rst = 0; if_req = 0; bus_ack = 1; bus_rdata = 32'h0000_9999;
      step();
      chk("rf_no_ack", {30'd0, if_ack, dm_ack}, 0);
      chk("rf_idle_read", {31'd0, bus_read}, 0);
      step();
      chk("rf_late_ack", {30'd0, if_ack, dm_ack}, 0);
      chk("rf_rdata_clr", if_rdata, 0);
      bus_ack = 0;
      step();

      // Back-to-back fetches
      if_req = 1; if_addr = 32'h0;
      step();
      chk("bb1_read", {31'd0, bus_read}, 1);
      chk("bb1_addr", bus_addr, 32'h0);
      bus_ack = 1; bus_rdata = 32'h0000_0013;
      step();
      chk("bb1_ack", {31'd0, if_ack}, 1);
      chk("bb1_rdata", if_rdata, 32'h0000_0013);
      chk("bb1_idle", {31'd0, bus_read}, 0);
      if_addr = 32'h4; bus_ack = 0;
      step();
      chk("bb2_read", {31'd0, bus_read}, 1);
      chk("bb2_addr", bus_addr, 32'h4);
      chk("bb2_ack_low", {31'd0, if_ack}, 0);
      bus_ack = 1; bus_rdata = 32'h0000_0293;
      step();
      chk("bb2_ack", {31'd0, if_ack}, 1);
      chk("bb2_rdata", if_rdata, 32'h0000_0293);
      if_req = 0; bus_ack = 0;
      step();
      chk("bb_end", {30'd0, bus_read, if_ack}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
